// File: rtl/shift_deser.sv
// Serial-to-parallel deserializer with a holding register and ready/valid handshake on both sides.
// Define SHIFT_DESER_PARITY_EN to append one even-parity bit to every frame and report it on parity_err.
module shift_deser #(
    parameter int DATA_WIDTH = 16,
    parameter bit LSB_FIRST  = 1'b0
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic                                  din,
    input  logic                                  din_valid,
    output logic                                  din_ready,
    input  logic                                  clear,
    output logic [DATA_WIDTH-1:0]                 dout,
    output logic                                  dout_valid,
    input  logic                                  dout_ready,
    output logic [$clog2(DATA_WIDTH+1)-1:0]       bit_count,
    output logic                                  parity_err
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
`ifdef SHIFT_DESER_PARITY_EN
    localparam int LAST = DATA_WIDTH;
`else
    localparam int LAST = DATA_WIDTH - 1;
`endif
    localparam logic [CW-1:0] LAST_CNT = CW'(LAST);

    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_next;
    logic                  last_bit;
    logic                  accept;
    logic                  complete;

    generate
        if (DATA_WIDTH == 1) begin : g_single
            assign shift_next = din;
            logic unused_shift;
            assign unused_shift = ^shift_reg;
        end else if (LSB_FIRST) begin : g_lsb
            assign shift_next = {din, shift_reg[DATA_WIDTH-1:1]};
        end else begin : g_msb
            assign shift_next = {shift_reg[DATA_WIDTH-2:0], din};
        end
    endgenerate

    // Stall only the frame's final bit, and only when the holding register cannot drain this cycle.
    assign last_bit  = (bit_count == LAST_CNT);
    assign din_ready = !(last_bit && dout_valid && !dout_ready);
    assign accept    = din_valid && din_ready;
    assign complete  = accept && last_bit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shift_reg  <= '0;
            bit_count  <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (clear) begin
            shift_reg  <= '0;
            bit_count  <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            if (accept) begin
                bit_count <= last_bit ? '0 : bit_count + CW'(1);
`ifdef SHIFT_DESER_PARITY_EN
                if (!last_bit) begin
                    shift_reg <= shift_next;
                end
`else
                shift_reg <= shift_next;
`endif
            end
            if (complete) begin
`ifdef SHIFT_DESER_PARITY_EN
                dout <= shift_reg;
`else
                dout <= shift_next;
`endif
                dout_valid <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

`ifdef SHIFT_DESER_PARITY_EN
    // Even parity over data plus parity bit: a nonzero XOR flags the frame as corrupt.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            parity_err <= 1'b0;
        end else if (clear) begin
            parity_err <= 1'b0;
        end else if (complete) begin
            parity_err <= (^shift_reg) ^ din;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_deser.sv
// Self-checking bench for shift_deser: three instances (8-bit MSB-first, 8-bit LSB-first, 1-bit)
// share stimulus and are compared each cycle against a bit-list reference model.
module tb_shift_deser;

`ifdef SHIFT_DESER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int F8 = 8 + PAR;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn, din, din_valid, clear, dout_ready;
    logic [7:0] dout0, dout1;
    logic       dout2;
    logic       rdy0, rdy1, rdy2, v0, v1, v2, pe0, pe1, pe2;
    logic [3:0] bc0, bc1;
    logic [0:0] bc2;

    shift_deser #(.DATA_WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid), .din_ready(rdy0),
        .clear(clear), .dout(dout0), .dout_valid(v0), .dout_ready(dout_ready),
        .bit_count(bc0), .parity_err(pe0));
    shift_deser #(.DATA_WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid), .din_ready(rdy1),
        .clear(clear), .dout(dout1), .dout_valid(v1), .dout_ready(dout_ready),
        .bit_count(bc1), .parity_err(pe1));
    shift_deser #(.DATA_WIDTH(1), .LSB_FIRST(1'b0)) u_one (
        .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid), .din_ready(rdy2),
        .clear(clear), .dout(dout2), .dout_valid(v2), .dout_ready(dout_ready),
        .bit_count(bc2), .parity_err(pe2));

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: each instance keeps the list of bits received in the current frame.
    int         pn[3];
    bit         pbits[3][9];
    logic [7:0] mdout[3];
    bit         mvalid[3];
    bit         merr[3];
    bit         mready[3];

    function automatic int dw_of(int k);
        return (k == 2) ? 1 : 8;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            pn[k] = 0; mdout[k] = 8'h00; mvalid[k] = 0; merr[k] = 0;
        end
    endfunction

    function automatic void model_ready();
        for (int k = 0; k < 3; k++)
            mready[k] = !((pn[k] == dw_of(k) + PAR - 1) && mvalid[k] && !dout_ready);
    endfunction

    function automatic void model_edge();
        for (int k = 0; k < 3; k++) begin
            if (clear) begin
                pn[k] = 0; mdout[k] = 8'h00; mvalid[k] = 0; merr[k] = 0;
            end else begin
                bit acc  = din_valid && mready[k];
                bit hs   = mvalid[k] && dout_ready;
                bit done = 0;
                if (acc) begin
                    pbits[k][pn[k]] = din;
                    pn[k]++;
                    if (pn[k] == dw_of(k) + PAR) begin
                        logic [7:0] w = 8'h00;
                        bit x = 0;
                        for (int i = 0; i < dw_of(k); i++) begin
                            if (k == 1) w[i] = pbits[k][i];
                            else        w[dw_of(k)-1-i] = pbits[k][i];
                        end
                        for (int i = 0; i < pn[k]; i++) x ^= pbits[k][i];
                        mdout[k]  = w;
                        merr[k]   = (PAR != 0) ? x : 1'b0;
                        mvalid[k] = 1;
                        pn[k]     = 0;
                        done      = 1;
                    end
                end
                if (!done && hs) mvalid[k] = 0;
            end
        end
    endfunction

    function automatic int a_dout(int k);
        return (k == 0) ? int'(dout0) : (k == 1) ? int'(dout1) : int'(dout2);
    endfunction
    function automatic int a_valid(int k);
        return (k == 0) ? int'(v0) : (k == 1) ? int'(v1) : int'(v2);
    endfunction
    function automatic int a_cnt(int k);
        return (k == 0) ? int'(bc0) : (k == 1) ? int'(bc1) : int'(bc2);
    endfunction
    function automatic int a_err(int k);
        return (k == 0) ? int'(pe0) : (k == 1) ? int'(pe1) : int'(pe2);
    endfunction
    function automatic int a_rdy(int k);
        return (k == 0) ? int'(rdy0) : (k == 1) ? int'(rdy1) : int'(rdy2);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", nm, $time, act, exp);
        else n_pass++;
    endtask

    task automatic check_ready();
        model_ready();
        for (int k = 0; k < 3; k++) chk($sformatf("din_ready[%0d]", k), a_rdy(k), int'(mready[k]));
    endtask

    task automatic check_outs();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("dout[%0d]", k), a_dout(k), int'(mdout[k]));
            chk($sformatf("dout_valid[%0d]", k), a_valid(k), int'(mvalid[k]));
            chk($sformatf("bit_count[%0d]", k), a_cnt(k), pn[k]);
            chk($sformatf("parity_err[%0d]", k), a_err(k), int'(merr[k]));
        end
    endtask

    // Called at a falling edge: drive, check combinational ready, clock once, check registered outputs.
    task automatic step(input logic d, input logic dv, input logic dr, input logic cl);
        din = d; din_valid = dv; dout_ready = dr; clear = cl;
        #1;
        check_ready();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_outs();
    endtask

    function automatic logic bit_of(input logic [7:0] w, input int i);
        return (i < 8) ? w[7-i] : ^w;
    endfunction

    typedef struct {
        logic       din;
        logic       dv;
        logic       dr;
        logic [7:0] e_msb;
        logic [7:0] e_lsb;
        logic       e_valid;
        int         e_cnt;
    } vec_t;

    vec_t       tbl[10];
    logic [7:0] seq;

    initial begin
        seq = 8'b1011_0010;
        for (int i = 0; i < 8; i++) begin
            tbl[i].din     = seq[7-i];
            tbl[i].dv      = 1'b1;
            tbl[i].dr      = 1'b0;
            tbl[i].e_valid = (i == 7) && (PAR == 0);
            tbl[i].e_cnt   = tbl[i].e_valid ? 0 : i + 1;
            tbl[i].e_msb   = tbl[i].e_valid ? 8'hB2 : 8'h00;
            tbl[i].e_lsb   = tbl[i].e_valid ? 8'h4D : 8'h00;
        end
        tbl[8] = '{din: 1'b0, dv: (PAR != 0), dr: 1'b0, e_msb: 8'hB2, e_lsb: 8'h4D, e_valid: 1'b1, e_cnt: 0};
        tbl[9] = '{din: 1'b0, dv: 1'b0, dr: 1'b1, e_msb: 8'hB2, e_lsb: 8'h4D, e_valid: 1'b0, e_cnt: 0};

        // Reset state, including ready during reset
        resetn = 1'b0; din = 1'b0; din_valid = 1'b0; clear = 1'b0; dout_ready = 1'b0;
        model_reset();
        #2;
        check_ready();
        check_outs();
        @(negedge clk);
        resetn = 1'b1;

        // Table: 1,0,1,1,0,0,1,0 -> B2 (MSB-first) / 4D (LSB-first)
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].din, tbl[i].dv, tbl[i].dr, 1'b0);
            chk($sformatf("tbl%0d_msb_dout", i), int'(dout0), int'(tbl[i].e_msb));
            chk($sformatf("tbl%0d_lsb_dout", i), int'(dout1), int'(tbl[i].e_lsb));
            chk($sformatf("tbl%0d_valid", i), int'(v0), int'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_count", i), int'(bc0), tbl[i].e_cnt);
        end

        // Backpressure: A5 held while 3C stalls on its final bit, then simultaneous consume+complete
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < F8; i++) step(bit_of(8'hA5, i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < F8 - 1; i++) step(bit_of(8'h3C, i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(bit_of(8'h3C, F8 - 1), 1'b1, 1'b0, 1'b0);
        chk("stall_ready", int'(rdy0), 0);
        chk("stall_hold_dout", int'(dout0), 8'hA5);
        chk("stall_count", int'(bc0), F8 - 1);
        step(bit_of(8'h3C, F8 - 1), 1'b1, 1'b1, 1'b0);
        chk("swap_dout", int'(dout0), 8'h3C);
        chk("swap_valid", int'(v0), 1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("drain_valid", int'(v0), 0);

        // Asynchronous reset mid-word, then a fresh FF word, then clear with din_valid high
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(i[0] ? 1'b0 : 1'b1, 1'b1, 1'b1, 1'b0);
        resetn = 1'b0;
        #1;
        model_reset();
        chk("async_rst_count", int'(bc0), 0);
        chk("async_rst_valid", int'(v0), 0);
        check_ready();
        check_outs();
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < F8; i++) step(bit_of(8'hFF, i), 1'b1, 1'b0, 1'b0);
        chk("post_rst_dout", int'(dout0), 8'hFF);
        chk("post_rst_valid", int'(v0), 1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("clear_count", int'(bc0), 0);
        chk("clear_valid", int'(v0), 0);

`ifndef SHIFT_DESER_PARITY_EN
        // One-bit word: every accepted bit is a complete word
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("w1_a_dout", int'(dout2), 1); chk("w1_a_valid", int'(v2), 1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("w1_b_dout", int'(dout2), 0); chk("w1_b_valid", int'(v2), 1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("w1_c_dout", int'(dout2), 1); chk("w1_c_valid", int'(v2), 1);
`else
        // Parity: B2 with correct parity, then B2 with flipped parity
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(bit_of(8'hB2, i), 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("par_ok_dout", int'(dout0), 8'hB2);
        chk("par_ok_err", int'(pe0), 0);
        for (int i = 0; i < 8; i++) step(bit_of(8'hB2, i), 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("par_bad_dout", int'(dout0), 8'hB2);
        chk("par_bad_err", int'(pe0), 1);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++)
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 49) == 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_deser.md
SHIFT_DESER -- requirements
Module: shift_deser

Interface
REQ-001 Parameter DATA_WIDTH, default 16, word width in bits; SHALL be legal for any value >= 1, including 1.
REQ-002 Parameter LSB_FIRST, default 0; 0 = first received bit lands in dout[DATA_WIDTH-1], 1 = first received bit lands in dout[0].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 din  input  1  serial data bit.
REQ-006 din_valid  input  1  din qualifier.
REQ-007 din_ready  output  1  block can accept din this cycle.
REQ-008 clear  input  1  synchronous flush of all state.
REQ-009 dout  output  DATA_WIDTH  assembled word (holding register).
REQ-010 dout_valid  output  1  dout holds an unconsumed word.
REQ-011 dout_ready  input  1  consumer accepts dout this cycle.
REQ-012 bit_count  output  $clog2(DATA_WIDTH+1)  bits collected in the current partial word.
REQ-013 parity_err  output  1  parity status of the word in dout; constant 0 when parity is compiled out.

Function
REQ-014 Bit accepted when din_valid && din_ready; only accepted bits change the shift register or bit_count.
REQ-015 LSB_FIRST=0: shift_reg <= {shift_reg[DATA_WIDTH-2:0], din}; LSB_FIRST=1: shift_reg <= {din, shift_reg[DATA_WIDTH-1:1]}; DATA_WIDTH=1: shift_reg <= din. No out-of-range slices in any case.
REQ-016 bit_count increments per accepted data bit; on the word's final bit it returns to 0 and the complete word, including the final bit, is written to dout in the same edge.
REQ-017 Word-complete edge SHALL set dout_valid=1. Consumer handshake (dout_valid && dout_ready) SHALL clear dout_valid unless a new word completes in the same edge.
REQ-018 Simultaneous completion and consumer handshake: new word replaces dout, dout_valid stays 1, no word lost or duplicated.
REQ-019 din_ready = !(final bit of frame pending && dout_valid && !dout_ready); combinational, no dependence on din_valid.
REQ-020 Latency: dout_valid rises on the edge that accepts a frame's final bit; no extra pipeline cycle.
REQ-021 dout and parity_err SHALL remain stable while dout_valid=1 and dout_ready=0.
REQ-022 clear=1 (sync): shift_reg, bit_count, dout, dout_valid, parity_err <= 0; takes priority over accept and handshake in the same cycle.
REQ-023 Partial words are never presented on dout.

Reset
REQ-024 resetn low SHALL immediately, without a clock edge, force shift_reg=0, bit_count=0, dout=0, dout_valid=0, parity_err=0.
REQ-025 din_ready SHALL be 1 during and after reset until a stall condition (REQ-019) arises.
REQ-026 Reset asserted mid-word discards the partial word; the first accepted bit after release starts a new word.

Configuration
REQ-027 Macro SHIFT_DESER_PARITY_EN defined: each frame is DATA_WIDTH data bits followed by one even-parity bit; the parity bit is not shifted into the data. bit_count counts 0..DATA_WIDTH and wraps to 0 after the parity bit.
REQ-028 With SHIFT_DESER_PARITY_EN defined, the word is written to dout on acceptance of the parity bit, and parity_err = XOR of the data bits and the parity bit is loaded in the same edge.
REQ-029 Without SHIFT_DESER_PARITY_EN: frame = DATA_WIDTH bits; parity_err tied 0; no parity logic synthesised.

Verification
REQ-030 DATA_WIDTH=8, LSB_FIRST=0: bits 1,0,1,1,0,0,1,0 on consecutive cycles -> dout=8'hB2, dout_valid=1 on the edge of the 8th bit.
REQ-031 DATA_WIDTH=8, LSB_FIRST=1: same bit sequence -> dout=8'h4D.
REQ-032 dout_ready=0, two words 8'hA5 then 8'h3C streamed -> first held stable; din_ready=0 with 7 bits of the second collected; raising dout_ready -> 8'hA5 consumed, 8'h3C presented next cycle, no loss.
REQ-033 resetn low after 5 bits, then release, then 8 bits of 8'hFF -> dout=8'hFF, no remnant of the old bits; clear=1 with din_valid=1 -> bit_count=0, dout_valid=0.
REQ-034 DATA_WIDTH=1: din=1,0,1 -> dout_valid every accepted cycle, dout follows 1,0,1.
REQ-035 SHIFT_DESER_PARITY_EN defined, DATA_WIDTH=8: 8'hB2 + parity 0 -> parity_err=0; 8'hB2 + parity 1 -> parity_err=1.
